// File: rtl/flash_read_cache.sv
// rtl/flash_read_cache.sv - direct-mapped one-word-per-line read cache in front of the SPI flash reader
// Optional: FLASH_CACHE_STATS_EN adds hit_count/miss_count outputs.
module flash_read_cache #(
    parameter int ADDR_W  = 20,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] word_address,
    input  logic              rstrb,
    output logic [31:0]       rdata,
    output logic              rbusy,
    input  logic              inv,
    output logic [ADDR_W-1:0] flash_word_address,
    output logic              flash_rstrb,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_rbusy
`ifdef FLASH_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                first_wait_q;
    logic [31:0]         data_q [LINES];
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINES-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         rdata_q;

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_idx;
    logic                accept;
    logic                lookup_hit;
    logic                fill;

    assign req_idx  = word_address[INDEX_W-1:0];
    assign req_tag  = word_address[ADDR_W-1:INDEX_W];
    assign fill_idx = addr_q[INDEX_W-1:0];
    assign accept   = (state_q == S_IDLE) && rstrb;
    // A simultaneous invalidate forces the access down the miss path.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !inv;
    // The reader raises busy one cycle after its strobe, so the first WAIT cycle is blind.
    assign fill = (state_q == S_WAIT) && !first_wait_q && !flash_rbusy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !lookup_hit) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (fill) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rbusy       = (state_q == S_REQ) || (state_q == S_WAIT);
        flash_rstrb = (state_q == S_REQ);
    end

    always_comb begin
        valid_d = valid_q;
        if (inv) valid_d = '0;
        if (fill) valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
            first_wait_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            first_wait_q <= (state_q == S_REQ);
            if (accept && !lookup_hit) addr_q <= word_address;
            if (accept && lookup_hit) begin
                rdata_q <= data_q[req_idx];
            end else if (fill) begin
                rdata_q <= flash_rdata;
            end
        end
    end

    // Line storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fill_idx] <= flash_rdata;
            tag_q[fill_idx]  <= addr_q[ADDR_W-1:INDEX_W];
        end
    end

    assign rdata              = rdata_q;
    assign flash_word_address = addr_q;

`ifdef FLASH_CACHE_STATS_EN
    logic [31:0] hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        hit_d  = inv ? 32'd0 : hit_q;
        miss_d = inv ? 32'd0 : miss_q;
        if (accept && lookup_hit)  hit_d  = hit_d + 32'd1;
        if (accept && !lookup_hit) miss_d = miss_d + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_flash_read_cache.sv
// tb/tb_flash_read_cache.sv - directed-vector bench for flash_read_cache with a latency-accurate flash reader model
module tb_flash_read_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] word_address = '0;
    logic        rstrb = 1'b0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        inv = 1'b0;
    logic [19:0] flash_word_address;
    logic        flash_rstrb;
    logic [31:0] flash_rdata;
    logic        flash_rbusy;
`ifdef FLASH_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad = 0;

    int          flash_busy_n = 1;
    int          fl_cnt = 0;
    int          strobes = 0;
    logic [19:0] fl_addr = '0;

    always #5 clk = ~clk;

    flash_read_cache dut (
        .clk                (clk),
        .reset              (reset),
        .word_address       (word_address),
        .rstrb              (rstrb),
        .rdata              (rdata),
        .rbusy              (rbusy),
        .inv                (inv),
        .flash_word_address (flash_word_address),
        .flash_rstrb        (flash_rstrb),
        .flash_rdata        (flash_rdata),
        .flash_rbusy        (flash_rbusy)
`ifdef FLASH_CACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    function automatic logic [31:0] flash_word(input logic [19:0] a);
        case (a)
            20'h00010: return 32'hDEADBEEF;
            20'h00020: return 32'h12345678;
            default:   return 32'hC000_0000 | {12'h000, a};
        endcase
    endfunction

    // Flash reader: busy rises the cycle after the strobe and stays up flash_busy_n cycles.
    always @(posedge clk) begin
        if (flash_rstrb) begin
            fl_cnt  <= flash_busy_n;
            fl_addr <= flash_word_address;
            strobes <= strobes + 1;
        end else if (fl_cnt != 0) begin
            fl_cnt <= fl_cnt - 1;
        end
    end
    assign flash_rbusy = (fl_cnt != 0);
    assign flash_rdata = flash_word(fl_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [19:0] a, input logic iv, input int inv_mid,
                           input int busy, input logic hit, input logic [31:0] d);
        int n;
        int s0;
        @(posedge clk); #1;
        flash_busy_n = busy;
        s0           = strobes;
        word_address = a;
        rstrb        = 1'b1;
        inv          = iv;
        @(posedge clk); #1;
        rstrb = 1'b0;
        inv   = 1'b0;
        n = 0;
        while (rbusy && n < 500) begin
            n++;
            inv = (n == inv_mid);
            @(posedge clk); #1;
        end
        inv = 1'b0;
        check({tag, "_busy_cycles"}, n, hit ? 0 : busy + 2);
        check({tag, "_rdata"}, rdata, d);
        check({tag, "_strobes"}, strobes - s0, hit ? 0 : 1);
        if (!hit) check({tag, "_flash_addr"}, {12'h000, fl_addr}, {12'h000, a});
    endtask

    typedef struct {
        logic [19:0] addr;
        logic        inv_now;
        int          inv_mid;
        int          busy;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int s0;
        int n;

        vecs[0]  = '{20'h00010, 1'b0, 0, 40, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{20'h00010, 1'b0, 0, 1,  1'b1, 32'hDEADBEEF};
        vecs[2]  = '{20'h00020, 1'b0, 0, 3,  1'b0, 32'h12345678};
        vecs[3]  = '{20'h00010, 1'b0, 0, 1,  1'b0, 32'hDEADBEEF};
        vecs[4]  = '{20'h00011, 1'b0, 0, 2,  1'b0, 32'hC0000011};
        vecs[5]  = '{20'h00012, 1'b0, 0, 5,  1'b0, 32'hC0000012};
        vecs[6]  = '{20'hFFFFF, 1'b0, 0, 2,  1'b0, 32'hC00FFFFF};
        vecs[7]  = '{20'hFFFFF, 1'b0, 0, 2,  1'b1, 32'hC00FFFFF};
        vecs[8]  = '{20'h00010, 1'b0, 0, 2,  1'b1, 32'hDEADBEEF};
        vecs[9]  = '{20'h00010, 1'b1, 0, 2,  1'b0, 32'hDEADBEEF};
        vecs[10] = '{20'h00011, 1'b0, 0, 2,  1'b0, 32'hC0000011};
        vecs[11] = '{20'h00012, 1'b0, 0, 2,  1'b0, 32'hC0000012};

        repeat (2) @(posedge clk);
        #1;
        check("reset_rbusy", rbusy, 0);
        check("reset_rdata", rdata, 0);
        check("reset_flash_rstrb", flash_rstrb, 0);
        check("reset_flash_addr", flash_word_address, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].inv_now, vecs[i].inv_mid,
                    vecs[i].busy, vecs[i].hit, vecs[i].data);
`ifdef FLASH_CACHE_STATS_EN
            if (i == 1) begin
                check("stats_hit", hit_count, 1);
                check("stats_miss", miss_count, 1);
            end
`endif
        end

        // Back-to-back hits on consecutive cycles.
        @(posedge clk); #1;
        s0 = strobes;
        rstrb = 1'b1;
        word_address = 20'h00010;
        @(posedge clk); #1;
        check("b2b_0_rdata", rdata, 32'hDEADBEEF);
        check("b2b_0_rbusy", rbusy, 0);
        word_address = 20'h00011;
        @(posedge clk); #1;
        check("b2b_1_rdata", rdata, 32'hC0000011);
        check("b2b_1_rbusy", rbusy, 0);
        word_address = 20'h00012;
        @(posedge clk); #1;
        rstrb = 1'b0;
        check("b2b_2_rdata", rdata, 32'hC0000012);
        check("b2b_2_rbusy", rbusy, 0);
        check("b2b_strobes", strobes - s0, 0);

        // Invalidate while idle, then the cached address must refetch.
        @(posedge clk); #1;
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        do_read("inv_idle", 20'h00010, 1'b0, 0, 2, 1'b0, 32'hDEADBEEF);

        // Invalidate mid-WAIT: fill still completes and marks only its own line valid.
        do_read("inv_wait", 20'h00011, 1'b0, 5, 10, 1'b0, 32'hC0000011);
        do_read("inv_wait_own", 20'h00011, 1'b0, 0, 2, 1'b1, 32'hC0000011);
        do_read("inv_wait_other", 20'h00010, 1'b0, 0, 2, 1'b0, 32'hDEADBEEF);

        // Reset during WAIT abandons the fill; the late flash data must be ignored.
        @(posedge clk); #1;
        flash_busy_n = 20;
        word_address = 20'h00040;
        rstrb = 1'b1;
        @(posedge clk); #1;
        rstrb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_wait_rbusy", rbusy, 0);
        check("rst_wait_rdata", rdata, 0);
        check("rst_wait_flash_addr", flash_word_address, 0);
        n = 0;
        while (flash_rbusy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("rst_wait_drain_bound", n < 100, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_late_rdata", rdata, 0);
        check("rst_late_rbusy", rbusy, 0);
`ifdef FLASH_CACHE_STATS_EN
        check("rst_stats_hit", hit_count, 0);
        check("rst_stats_miss", miss_count, 0);
`endif
        do_read("post_rst", 20'h00030, 1'b0, 0, 4, 1'b0, 32'hC0000030);
        do_read("post_rst_nofill", 20'h00040, 1'b0, 0, 2, 1'b0, 32'hC0000040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
